// File: rtl/sseg_pkg.sv
// Shared 7-segment constants, hex glyph table and the saturating
// sign-magnitude adder used by the accumulator.
package sseg_pkg;

  // Active-low glyphs for the sign digit (gfedcba)
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Widest operand sm_add_sat can handle
  localparam int SM_MAX_W = 32;

  // Active-low gfedcba patterns, entry k is hex digit k
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Saturating sign-magnitude add of two width-bit operands held in the low
  // bits of a and b. Returns the result in bits [width-1:0] and the overflow
  // flag in bit [width]; all higher bits are zero. A -0 operand counts as +0
  // and a zero result always carries a positive sign.
  function automatic logic [SM_MAX_W:0] sm_add_sat(
    input logic [SM_MAX_W-1:0] a,
    input logic [SM_MAX_W-1:0] b,
    input int                  width
  );
    logic [SM_MAX_W-1:0] mask;
    logic [SM_MAX_W-1:0] ma;
    logic [SM_MAX_W-1:0] mb;
    logic [SM_MAX_W-1:0] mag;
    logic                sa;
    logic                sb;
    logic                sign;
    logic                ovf;
    logic [SM_MAX_W:0]   res;
    mask = (SM_MAX_W'(1) << (width - 1)) - SM_MAX_W'(1);
    ma   = a & mask;
    mb   = b & mask;
    sa   = a[width-1];
    sb   = b[width-1] & (mb != '0);
    ovf  = 1'b0;
    if (sa == sb) begin
      // Sum of two magnitudes below 2^(width-1) always fits in width bits
      mag  = ma + mb;
      sign = sa;
      if (mag > mask) begin
        mag = mask;
        ovf = 1'b1;
      end
    end else if (ma >= mb) begin
      mag  = ma - mb;
      sign = sa;
    end else begin
      mag  = mb - ma;
      sign = sb;
    end
    if (mag == '0) sign = 1'b0;
    res            = {1'b0, mag};
    res[width-1]   = sign;
    res[width]     = ovf;
    return res;
  endfunction

endpackage

// File: rtl/sseg_hex_dec.sv
// Combinational hex-to-7-segment decoder with decimal point, active-low.
module sseg_hex_dec
  import sseg_pkg::*;
(
  input  logic [3:0] i_hex,
  input  logic       i_dp,
  output logic [7:0] o_sseg
);

  // Look up the glyph and drive dp low when it should be lit
  always_comb begin
    o_sseg = {~i_dp, HEX_SEG[i_hex]};
  end

endmodule

// File: rtl/sm_accum_disp.sv
// Sign-magnitude accumulator with saturation, sticky overflow and a
// time-multiplexed 7-segment display scanner.
module sm_accum_disp
  import sseg_pkg::*;
#(
  parameter int N            = 8,
  parameter int DIGITS       = 4,
  parameter int REFRESH_BITS = 18
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N-1:0]      data_in,
  input  logic              add,
  input  logic              clr,
  output logic [DIGITS-1:0] an,
  output logic [7:0]        sseg,
  output logic [N-1:0]      acc,
  output logic              ovf
);

  localparam int IDX_W  = $clog2(DIGITS);
  localparam int DISP_W = 4 * DIGITS;

  logic [N-1:0]            r_acc;
  logic                    r_ovf;
  logic                    r_add_q;
  logic [REFRESH_BITS-1:0] r_cnt;
  logic [DIGITS-1:0]       r_an;
  logic [7:0]              r_sseg;

  logic                    w_pulse;
  logic [N:0]              w_sum;
  logic [IDX_W-1:0]        w_idx;
  logic [DISP_W-1:0]       w_mag_ext;
  logic [3:0]              w_nib;
  logic [7:0]              w_hex_sseg;
  logic [7:0]              w_sign_sseg;

  assign w_pulse = add & ~r_add_q;

  // Candidate result and overflow for the current operand
  assign w_sum = (N+1)'(sm_add_sat(SM_MAX_W'(r_acc), SM_MAX_W'(data_in), N));

  // Digit index comes from the top bits of the free-running scan counter
  assign w_idx = r_cnt[REFRESH_BITS-1 -: IDX_W];

  // Magnitude zero-extended to a whole number of nibbles; leading zeros show '0'
  assign w_mag_ext = DISP_W'(r_acc[N-2:0]);
  assign w_nib     = w_mag_ext[{w_idx, 2'b00} +: 4];

  // Top digit: minus bar for negative values, dp marks overflow
  assign w_sign_sseg = {~r_ovf, (r_acc[N-1] ? SEG_MINUS : SEG_BLANK)};

  sseg_hex_dec u_hex_dec (
    .i_hex  (w_nib),
    .i_dp   (1'b0),
    .o_sseg (w_hex_sseg)
  );

  // Accumulator, overflow flag and add-button edge detector
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_add_q <= 1'b0;
    end else begin
      r_add_q <= add;
      if (clr) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
      end else if (w_pulse) begin
        r_acc <= w_sum[N-1:0];
        r_ovf <= r_ovf | w_sum[N];
      end
    end
  end

  // Scan counter and registered digit enables/segments
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_an   <= '1;
      r_sseg <= 8'hFF;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      r_an  <= ~(DIGITS'(1) << w_idx);
      if (w_idx == IDX_W'(DIGITS - 1)) r_sseg <= w_sign_sseg;
      else                             r_sseg <= w_hex_sseg;
    end
  end

  assign an   = r_an;
  assign sseg = r_sseg;
  assign acc  = r_acc;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_sm_accum_disp.sv
// Directed plus randomized bench for sm_accum_disp (N=8, DIGITS=4,
// REFRESH_BITS=4) against an integer-arithmetic reference model.
module tb_sm_accum_disp;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] data_in;
  logic       add;
  logic       clr;
  logic [3:0] an;
  logic [7:0] sseg;
  logic [7:0] acc;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  // Reference model state: accumulator as a plain signed integer
  int         m_acc;
  bit         m_ovf;
  bit         m_add_q;
  int         m_cnt;
  logic [3:0] m_an;
  logic [7:0] m_sseg;

  logic [6:0] hex_t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  sm_accum_disp #(.N(8), .DIGITS(4), .REFRESH_BITS(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .data_in (data_in),
    .add     (add),
    .clr     (clr),
    .an      (an),
    .sseg    (sseg),
    .acc     (acc),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  function automatic int sm_to_int(input logic [7:0] v);
    return v[7] ? -int'(v[6:0]) : int'(v[6:0]);
  endfunction

  function automatic logic [7:0] int_to_sm(input int x);
    return (x < 0) ? {1'b1, 7'(-x)} : {1'b0, 7'(x)};
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: advance the model with the inputs sampled at this edge, then compare
  task automatic step();
    int idx;
    int mag;
    int s;
    @(posedge clk);
    if (!reset_n) begin
      m_acc   = 0;
      m_ovf   = 1'b0;
      m_add_q = 1'b0;
      m_cnt   = 0;
      m_an    = 4'hF;
      m_sseg  = 8'hFF;
    end else begin
      idx  = m_cnt / 4;
      mag  = (m_acc < 0) ? -m_acc : m_acc;
      m_an = 4'(~(32'd1 << idx));
      if (idx == 3) m_sseg = {~m_ovf, ((m_acc < 0) ? 7'h3F : 7'h7F)};
      else          m_sseg = {1'b1, hex_t[(mag >> (4 * idx)) & 15]};
      if (clr) begin
        m_acc = 0;
        m_ovf = 1'b0;
      end else if (add && !m_add_q) begin
        s = m_acc + sm_to_int(data_in);
        if (s > 127) begin
          s = 127;
          m_ovf = 1'b1;
        end else if (s < -127) begin
          s = -127;
          m_ovf = 1'b1;
        end
        m_acc = s;
      end
      m_add_q = add;
      m_cnt   = (m_cnt + 1) % 16;
    end
    #1;
    chk("acc",  acc,              int_to_sm(m_acc));
    chk("ovf",  8'(ovf),          8'(m_ovf));
    chk("an",   8'(an),           8'(m_an));
    chk("sseg", sseg,             m_sseg);
  endtask

  task automatic do_add(input logic [7:0] d);
    data_in = d;
    add     = 1'b1;
    step();
    add     = 1'b0;
    step();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
  endtask

  // Step until the given digit enable appears, bounded by one scan period plus margin
  task automatic wait_an(input logic [3:0] want, input string tag);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (an === want) found = 1'b1;
    end
    chk(tag, 8'(found), 8'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    add     = 1'b0;
    clr     = 1'b0;
    data_in = 8'h00;

    // Reset
    step();
    step();
    chk("rst_an",   8'(an),  8'h0F);
    chk("rst_sseg", sseg,    8'hFF);
    chk("rst_acc",  acc,     8'h00);
    chk("rst_ovf",  8'(ovf), 8'h00);
    reset_n = 1'b1;
    step();
    chk("first_an",   8'(an), 8'h0E);
    chk("first_sseg", sseg,   8'hC0);

    // Mixed signs
    do_add(8'h05);
    chk("mix_p5", acc, 8'h05);
    do_add(8'h87);
    chk("mix_m2", acc, 8'h82);
    wait_an(4'b0111, "mix_find_sign");
    chk("mix_sign_digit", sseg, 8'hBF);
    wait_an(4'b1110, "mix_find_d0");
    chk("mix_digit0", sseg, 8'hA4);

    // Saturation
    do_clr();
    do_add(8'h64);
    chk("sat_100", acc, 8'h64);
    do_add(8'h32);
    chk("sat_acc", acc, 8'h7F);
    chk("sat_ovf", 8'(ovf), 8'h01);
    wait_an(4'b0111, "sat_find_sign");
    chk("sat_sign_digit", sseg, 8'h7F);
    do_add(8'h81);
    chk("sat_after_m1", acc, 8'h7E);
    chk("sat_ovf_sticky", 8'(ovf), 8'h01);

    // Zero rules
    do_clr();
    do_add(8'h03);
    do_add(8'h80);
    chk("zero_neg0_operand", acc, 8'h03);
    do_add(8'h83);
    chk("zero_no_neg0", acc, 8'h00);
    wait_an(4'b0111, "zero_find_sign");
    chk("zero_sign_blank", sseg, 8'hFF);

    // Held add accumulates once
    data_in = 8'h01;
    add     = 1'b1;
    for (int k = 0; k < 10; k++) step();
    add     = 1'b0;
    step();
    chk("hold_once", acc, 8'h01);

    // clr beats a simultaneous add edge
    do_add(8'h7F);
    chk("prio_pre_ovf", 8'(ovf), 8'h01);
    data_in = 8'h05;
    clr     = 1'b1;
    add     = 1'b1;
    step();
    chk("prio_acc", acc, 8'h00);
    chk("prio_ovf", 8'(ovf), 8'h00);
    clr = 1'b0;
    add = 1'b0;
    step();

    // Reset during an add edge, mid-scan
    do_add(8'h09);
    step();
    data_in = 8'h05;
    add     = 1'b1;
    reset_n = 1'b0;
    step();
    chk("midrst_acc",  acc,    8'h00);
    chk("midrst_an",   8'(an), 8'h0F);
    chk("midrst_sseg", sseg,   8'hFF);
    reset_n = 1'b1;
    add     = 1'b0;
    step();
    chk("midrst_restart_an", 8'(an), 8'h0E);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      int r;
      r       = int'($urandom_range(0, 63));
      data_in = 8'($urandom);
      add     = 1'($urandom_range(0, 1));
      clr     = (r < 3);
      reset_n = (r != 63);
      step();
    end
    reset_n = 1'b1;
    clr     = 1'b0;
    add     = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm_accum_disp.md
Name: sm_accum_disp

Overview:
- Parametrised sign-magnitude accumulator with a time-multiplexed 7-segment display driver, for board-level switch/button test designs.
- Adds the switch operand to a registered running total on each add-button press.
- Provides saturation and a sticky overflow flag.
- Scans DIGITS multiplexed LED digits: hex magnitude on the low digits, sign and overflow on the top digit.

Parameters:
- N, 8, total operand/accumulator width; bit N-1 is the sign, bits N-2..0 are the magnitude.
- DIGITS, 4, number of multiplexed digits; one of 2, 4 or 8; DIGITS-1 >= ceil((N-1)/4).
- REFRESH_BITS, 18, width of the scan counter; the digit index is the top log2(DIGITS) bits.

Ports:
- clk  input  1  system clock; the only clock.
- reset_n  input  1  synchronous reset, active-low.
- data_in  input  N  sign-magnitude operand from the switches.
- add  input  1  debounced level; a rising edge triggers one accumulation.
- clr  input  1  debounced level; while high, clears the accumulator and the overflow flag.
- an  output  DIGITS  digit enables, active-low, one-hot-low.
- sseg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- acc  output  N  current accumulator value, sign-magnitude.
- ovf  output  1  sticky overflow flag.

Behaviour:
- Reset: everything is sampled on the clk rising edge with reset_n=0.
  - acc=0, ovf=0, scan counter=0, add_q=0.
  - an = all ones, sseg = 8'hFF.
  - Reset mid-operation aborts a pending add and blanks the display on the same edge.
- Edge detect: add_q is registered. An add pulse is add & ~add_q.
  - acc updates on the edge where the pulse is seen, so the new value is visible one cycle after add is first sampled high.
  - Holding add high produces exactly one accumulation.
- clr has priority over an add pulse in the same cycle: acc=0, ovf=0.
- Add rules (operand magnitude M_b, accumulator magnitude M_a):
  - An operand of -0 is treated as +0.
  - Same signs: sum = M_a + M_b computed N bits wide.
    - If sum > 2^(N-1)-1: magnitude saturates to 2^(N-1)-1, the sign is kept, ovf is set to 1 (sticky until clr or reset).
  - Different signs: result magnitude = larger - smaller; result sign = sign of the larger magnitude.
    - Equal magnitudes give +0; the sign bit is forced to 0.
  - acc never holds -0.
- Scan:
  - The counter increments every cycle and wraps at 2^REFRESH_BITS - 1 back to 0.
  - Digit index i = counter[REFRESH_BITS-1 -: log2(DIGITS)].
  - Outputs are registered, so an/sseg lag the index by one cycle.
  - an[i]=0, all other enables 1.
- Digit content:
  - i < DIGITS-1: hex nibble i of the zero-extended magnitude, with dp off (sseg[7]=1).
  - i = DIGITS-1: gfedcba = 7'b0111111 (middle bar) if acc sign is 1, else 7'b1111111 (blank). dp is lit (sseg[7]=0) when ovf=1.
  - Leading-zero digits display '0'; there is no blanking.
- The display reflects acc from the previous cycle; no tearing requirement beyond that.

Decomposition:
- Shared package sseg_pkg holds:
  - constants SEG_BLANK=7'b1111111 and SEG_MINUS=7'b0111111;
  - the 16-entry hex segment table (for example, '0' = 7'b1000000);
  - function sm_add_sat(a, b, width), returning {ovf, result}.
- One sub-module, sseg_hex_dec: 4-bit hex plus dp in, 8-bit active-low segments out, purely combinational.
- The accumulator, edge detect and scan logic stay in the top level.

Test Plan (N=8, DIGITS=4, REFRESH_BITS=4 in simulation):
- Reset: reset_n=0 for 2 cycles -> an=4'b1111, sseg=8'hFF, acc=8'h00, ovf=0. After release, when an=4'b1110, sseg=8'b1_1000000 ('0').
- Mixed signs: data_in=8'h05 + add pulse -> acc=8'h05. Then data_in=8'h87 (-7) + add pulse -> acc=8'h82 (-2). The an=4'b0111 slot shows sseg=8'b1_0111111; the an=4'b1110 slot shows '2' (8'b1_0100100).
- Saturation: acc=8'h64 (+100), data_in=8'h32 (+50), add pulse -> acc=8'h7F, ovf=1. The an=4'b0111 slot shows sseg=8'b0_1111111. A later add of -1 gives 8'h7E with ovf still 1.
- Zero rules: acc=8'h03, add data_in=8'h80 (-0) -> acc=8'h03. Then add 8'h83 -> acc=8'h00 (not 8'h80); the sign digit is blank.
- Edge and priority: add held high 10 cycles with data_in=8'h01 -> acc increases by exactly 1. clr and an add edge in the same cycle -> acc=8'h00, ovf=0.
- Mid-operation reset: reset_n=0 on the cycle an add pulse occurs, during an active scan -> the add is discarded; on the next edge acc=0, an=4'b1111, sseg=8'hFF; scanning restarts from digit 0.
